// File: rtl/router_fifo_pkg.sv
// Shared router definitions: byte width, buffer depth, header field layout and
// the stored entry format used by the per-port output buffers.
package router_fifo_pkg;

  localparam int BYTE_W      = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int ADDR_MSB    = 1;
  localparam int ADDR_LSB    = 0;
  localparam int PKT_CNT_W   = 7;

  typedef struct packed {
    logic              hdr_flag;
    logic [BYTE_W-1:0] data;
  } fifo_entry_t;

  // Bytes still to be delivered once a header is read: payload length plus parity.
  function automatic logic [PKT_CNT_W-1:0] hdr_pkt_count(
      input logic [HDR_LEN_MSB-HDR_LEN_LSB:0] len);
    return {1'b0, len} + PKT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router. Stores header-tagged bytes and
// tracks packet progress on the read side so the output is zeroed between packets.
module router_fifo
  import router_fifo_pkg::*;
#(
  parameter int  DEPTH = FIFO_DEPTH,
  parameter int  DW    = BYTE_W,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          soft_reset,
  input  logic          write_enb,
  input  logic          read_enb,
  input  logic          lfd_state,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          full,
  output logic          empty,
  output logic          pkt_active
);

  localparam int AW = PTR_W - 1;

  logic [DW:0]            mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PKT_CNT_W-1:0]   pkt_count;
  logic [DW:0]            rd_word;
  logic                   flush;
  logic                   wr_acc;
  logic                   rd_acc;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pkt_active = (pkt_count != '0);

  assign flush   = !resetn || soft_reset;
  assign wr_acc  = write_enb && !full;
  assign rd_acc  = read_enb && !empty;
  assign rd_word = mem[rd_ptr[AW-1:0]];

  // Storage: bit DW carries the header flag, never cleared except by overwrite.
  always_ff @(posedge clk) begin
    if (!flush && wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  // Read stage: one-cycle read latency, packet byte counting, output zeroing.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_count <= '0;
      data_out  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        data_out <= rd_word[DW-1:0];
        if (rd_word[DW]) begin
          pkt_count <= hdr_pkt_count(rd_word[HDR_LEN_MSB:HDR_LEN_LSB]);
        end else if (pkt_count != '0) begin
          pkt_count <= pkt_count - PKT_CNT_W'(1);
        end
      end else if (pkt_count == '0) begin
        data_out <= '0;
      end
    end
  end

endmodule
